regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 43 ++++
 rtl/regfile_sb.sv | 110 +++++++++++
 tb/tb_regfile_sb.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Feature macro REGFILE_SB_BYPASS_EN is consumed by regfile_sb, not here.
package regfile_pkg;

  localparam int DEF_ADDRESS_WIDTH = 5;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int A0_INDEX          = 10;

  typedef logic [DEF_ADDRESS_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0]    reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit tracker: reservations set a pending bit, writes retire it.
// A same-edge reserve and write leaves the register busy for the new producer.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int NUM_WR        = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_WR-1:0]                 we,
  input  logic [NUM_WR*ADDRESS_WIDTH-1:0]   wa,
  input  logic                              rsv_en,
  input  logic [ADDRESS_WIDTH-1:0]          rsv_ad,
  output logic [2**ADDRESS_WIDTH-1:0]       busy
);

  localparam int DEPTH = 2**ADDRESS_WIDTH;

  logic [DEPTH-1:0] clr;
  logic [DEPTH-1:0] set;
  logic [DEPTH-1:0] busy_next;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    clr = '0;
    set = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (we[k]) clr[wa[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = 1'b1;
    end
    if (rsv_en) set[rsv_ad] = 1'b1;
    // Set after clear: the newest producer owns the register.
    busy_next    = (busy & ~clr) | set;
    busy_next[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignment only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with x0 hardwired to zero and a busy scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int NUM_RD        = 2,
  parameter int NUM_WR        = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_WR-1:0]               WE,
  input  logic [NUM_WR*ADDRESS_WIDTH-1:0] WA,
  input  logic [NUM_WR*DATA_WIDTH-1:0]    WD,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0] RA,
  output logic [NUM_RD*DATA_WIDTH-1:0]    RD,
  output logic [NUM_RD-1:0]               RBUSY,
  input  logic                            RSV_EN,
  input  logic [ADDRESS_WIDTH-1:0]        RSV_AD,
  output logic [DATA_WIDTH-1:0]           a0,
  output logic                            WR_CONFLICT
);

  localparam int DEPTH = 2**ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0]    regs [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wa   [NUM_WR];
  logic [DATA_WIDTH-1:0]    wd   [NUM_WR];
  logic [ADDRESS_WIDTH-1:0] ra   [NUM_RD];
  logic [DEPTH-1:0]         busy;
  logic                     conflict_c;

  always_comb begin
    for (int k = 0; k < NUM_WR; k++) begin
      wa[k] = WA[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      wd[k] = WD[k*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int i = 0; i < NUM_RD; i++) ra[i] = RA[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  end

  // NOTE: the array is reset because an immediate all-zero clear is required;
  // that rules out a RAM macro, which is acceptable for a flop-based regfile.
  // Ports are visited in ascending order so the highest-index port lands last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (WE[k] && wa[k] != '0) regs[wa[k]] <= wd[k];
      end
    end
  end

  always_comb begin
    conflict_c = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (WE[i] && WE[j] && wa[i] == wa[j] && wa[i] != '0) conflict_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) WR_CONFLICT <= 1'b0;
    else        WR_CONFLICT <= conflict_c;
  end

  regfile_scoreboard #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_WR        (NUM_WR)
  ) u_scoreboard (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (WE),
    .wa     (WA),
    .rsv_en (RSV_EN),
    .rsv_ad (RSV_AD),
    .busy   (busy)
  );

  always_comb begin
    RD    = '0;
    RBUSY = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (ra[i] != '0) RD[i*DATA_WIDTH +: DATA_WIDTH] = regs[ra[i]];
      RBUSY[i] = busy[ra[i]];
`ifdef REGFILE_SB_BYPASS_EN
      // Forwarding is gated by rst_n so reset drives RD to zero immediately.
      if (rst_n && ra[i] != '0) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (WE[k] && wa[k] == ra[i]) begin
            RD[i*DATA_WIDTH +: DATA_WIDTH] = wd[k];
            if (!(RSV_EN && RSV_AD == ra[i])) RBUSY[i] = 1'b0;
          end
        end
      end
`endif
    end
  end

  generate
    if (A0_INDEX < DEPTH) begin : g_a0
      assign a0 = regs[A0_INDEX];
    end else begin : g_no_a0
      assign a0 = '0;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized bench for regfile_sb against an array-based reference model.
// Expectations follow REGFILE_SB_BYPASS_EN when the build defines it.
module tb_regfile_sb;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NW-1:0]     we = '0;
  logic [NW*AW-1:0]  wa = '0;
  logic [NW*DW-1:0]  wd = '0;
  logic [NR*AW-1:0]  ra = '0;
  logic [NR*DW-1:0]  rd;
  logic [NR-1:0]     rbusy;
  logic              rsv_en = 1'b0;
  logic [AW-1:0]     rsv_ad = '0;
  logic [DW-1:0]     a0;
  logic              wr_conflict;

  regfile_sb #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .NUM_RD        (NR),
    .NUM_WR        (NW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .WE          (we),
    .WA          (wa),
    .WD          (wd),
    .RA          (ra),
    .RD          (rd),
    .RBUSY       (rbusy),
    .RSV_EN      (rsv_en),
    .RSV_AD      (rsv_ad),
    .a0          (a0),
    .WR_CONFLICT (wr_conflict)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] m_regs [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_conf;
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] wa_of(int k);
    return wa[k*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] exp_rd(logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (!rst_n || a == 0) return '0;
    v = m_regs[a];
`ifdef REGFILE_SB_BYPASS_EN
    for (int k = 0; k < NW; k++) if (we[k] && wa_of(k) == a) v = wd[k*DW +: DW];
`endif
    return v;
  endfunction

  function automatic bit exp_busy(logic [AW-1:0] a);
    bit b;
    if (!rst_n || a == 0) return 1'b0;
    b = m_busy[a];
`ifdef REGFILE_SB_BYPASS_EN
    for (int k = 0; k < NW; k++)
      if (we[k] && wa_of(k) == a && !(rsv_en && rsv_ad == a)) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    m_conf = 1'b0;
  endtask

  // Architectural effect of one rising edge: writes in port order, then reservation.
  task automatic model_edge();
    if (!rst_n) return;
    m_conf = we[0] && we[1] && wa_of(0) == wa_of(1) && wa_of(0) != 0;
    for (int k = 0; k < NW; k++) begin
      if (we[k] && wa_of(k) != 0) begin
        m_regs[wa_of(k)] = wd[k*DW +: DW];
        m_busy[wa_of(k)] = 1'b0;
      end
    end
    if (rsv_en && rsv_ad != 0) m_busy[rsv_ad] = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < NR; i++) begin
      check($sformatf("%s_rd%0d", tag, i), rd[i*DW +: DW], exp_rd(ra[i*AW +: AW]));
      check($sformatf("%s_rbusy%0d", tag, i), 32'(rbusy[i]), 32'(exp_busy(ra[i*AW +: AW])));
    end
    check({tag, "_a0"}, a0, m_regs[10]);
    check({tag, "_conflict"}, 32'(wr_conflict), 32'(m_conf));
  endtask

  task automatic drive(input logic [NW-1:0] we_v, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                       input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                       input logic rsv_v, input logic [AW-1:0] rsv_a);
    we     = we_v;
    wa     = {wa1, wa0};
    wd     = {wd1, wd0};
    ra     = {ra1, ra0};
    rsv_en = rsv_v;
    rsv_ad = rsv_a;
  endtask

  // Check pre-edge outputs, take one edge, update the model, settle away from the edge.
  task automatic step(input string tag);
    #1;
    check_outputs(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 11));
  endfunction

  task automatic random_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      drive(NW'($urandom_range(0, 3)), rand_addr(), rand_addr(), $urandom, $urandom,
            rand_addr(), rand_addr(), 1'($urandom_range(0, 2) == 0), rand_addr());
      step("rand");
    end
  endtask

  initial begin
    model_reset();
    #12;
    rst_n = 1'b1;
    #1;

    drive('0, 0, 0, 0, 0, 0, 1, 1'b0, 0);
    step("reset_a");
    drive('0, 0, 0, 0, 0, 10, 31, 1'b0, 0);
    #1;
    check("reset_rd_a10", rd[DW-1:0], '0);
    check("reset_rd_a31", rd[2*DW-1:DW], '0);
    check("reset_rbusy", 32'(rbusy), '0);
    check("reset_a0", a0, '0);
    step("reset_b");

    drive(2'b01, 10, 0, 32'hDEADBEEF, 0, 10, 0, 1'b0, 0);
    step("wr_a10");
    drive(2'b01, 0, 0, 32'h5, 0, 10, 0, 1'b0, 0);
    #1;
    check("a10_rd", rd[DW-1:0], 32'hDEADBEEF);
    check("a10_a0", a0, 32'hDEADBEEF);
    step("wr_x0");
    drive('0, 0, 0, 0, 0, 0, 10, 1'b0, 0);
    #1;
    check("x0_still_zero", rd[DW-1:0], '0);
    step("x0_read");

    drive(2'b11, 5, 5, 32'h11, 32'h22, 5, 0, 1'b0, 0);
    step("dual_wr5");
    drive('0, 0, 0, 0, 0, 5, 0, 1'b0, 0);
    #1;
    check("conflict_set", 32'(wr_conflict), 32'd1);
    check("port1_wins", rd[DW-1:0], 32'h22);
    step("after_dual");
    #1;
    check("conflict_clear", 32'(wr_conflict), 32'd0);

    drive('0, 0, 0, 0, 0, 7, 0, 1'b1, 7);
    step("rsv7");
    drive(2'b01, 7, 0, 32'hAB, 0, 7, 0, 1'b1, 7);
    #1;
    check("rsv7_busy", 32'(rbusy[0]), 32'd1);
    step("rsv_wr7");
    drive('0, 0, 0, 0, 0, 7, 0, 1'b0, 0);
    #1;
    check("rsv_wr7_busy", 32'(rbusy[0]), 32'd1);
    check("rsv_wr7_data", rd[DW-1:0], 32'hAB);
    step("hold7");
    drive(2'b01, 7, 0, 32'hCD, 0, 7, 0, 1'b0, 0);
    step("wr7");
    drive('0, 0, 0, 0, 0, 7, 0, 1'b0, 0);
    #1;
    check("wr7_unbusy", 32'(rbusy[0]), 32'd0);
    step("idle7");

    drive(2'b01, 3, 0, 32'h1234, 0, 0, 3, 1'b0, 0);
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    check("bypass_rd1", rd[2*DW-1:DW], 32'h1234);
`else
    check("nobypass_rd1", rd[2*DW-1:DW], 32'h0);
`endif
    step("wr3");
    #1;
    check("wr3_after_edge", rd[2*DW-1:DW], 32'h1234);

    random_cycles(400);

    drive(2'b11, 10, 12, 32'hFFFF0000, 32'h0000FFFF, 10, 12, 1'b1, 13);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_rd0", rd[DW-1:0], '0);
    check("rst_rd1", rd[2*DW-1:DW], '0);
    check("rst_rbusy", 32'(rbusy), '0);
    check("rst_a0", a0, '0);
    check("rst_conflict", 32'(wr_conflict), '0);
    @(posedge clk);
    model_edge();
    #3;
    check("rst_hold_rd0", rd[DW-1:0], '0);
    check("rst_hold_a0", a0, '0);
    drive('0, 0, 0, 0, 0, 10, 12, 1'b0, 0);
    rst_n = 1'b1;
    step("post_rst");
    drive('0, 0, 0, 0, 0, 13, 12, 1'b0, 0);
    #1;
    check("post_rst_busy13", 32'(rbusy[0]), '0);
    check("post_rst_rd12", rd[2*DW-1:DW], '0);
    step("post_rst_b");

    random_cycles(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
